// File: rtl/int_issue_queue_if.sv
// Integer issue queue bus: dispatch port, CDB snoop and issue port toward the execution unit.
// The master modport is the dispatcher/execution side; the slave modport is the queue itself.
interface int_issue_queue_if #(
    parameter int unsigned TAG_W = 6
) ();
    typedef struct packed {
        logic [6:0]       opcode;
        logic [2:0]       func3;
        logic [6:0]       func7;
        logic [TAG_W-1:0] rd_tag;
        logic [31:0]      rs1_data;
        logic [31:0]      rs2_data;
    } int_fifo_data;

    typedef struct packed {
        logic             cdb_valid;
        logic [TAG_W-1:0] cdb_tag;
        logic [31:0]      cdb_result;
    } cdb_bfm;

    logic             dispatch_en;
    int_fifo_data     dispatch_data;
    logic [TAG_W-1:0] dispatch_rs1_tag;
    logic [TAG_W-1:0] dispatch_rs2_tag;
    logic             dispatch_rs1_valid;
    logic             dispatch_rs2_valid;
    logic             queue_full;
    cdb_bfm           cdb;
    logic             issue_queue_rdy;
    int_fifo_data     int_exec_fifo_data;
    logic             issue_done;

    modport master (
        output dispatch_en, dispatch_data, dispatch_rs1_tag, dispatch_rs2_tag,
        output dispatch_rs1_valid, dispatch_rs2_valid, cdb, issue_done,
        input  queue_full, issue_queue_rdy, int_exec_fifo_data
    );

    modport slave (
        input  dispatch_en, dispatch_data, dispatch_rs1_tag, dispatch_rs2_tag,
        input  dispatch_rs1_valid, dispatch_rs2_valid, cdb, issue_done,
        output queue_full, issue_queue_rdy, int_exec_fifo_data
    );
endinterface

// File: rtl/int_issue_queue.sv
// Integer reservation station: captures operands from dispatch and the CDB, issues the
// lowest-index ready entry, and keeps at most one op in flight in the integer unit.
module int_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6
) (
    input logic             clk,
    input logic             rst_n,
    int_issue_queue_if.slave bus
);
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OpW  = 17 + TAG_W;  // opcode, func3, func7, rd_tag
    localparam int unsigned OutW = OpW + 64;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e            state_q, state_d;
    logic [DEPTH-1:0]  valid_q, rs1_rdy_q, rs2_rdy_q;
    logic [OpW-1:0]    op_q       [DEPTH];
    logic [31:0]       rs1_data_q [DEPTH];
    logic [31:0]       rs2_data_q [DEPTH];
    logic [TAG_W-1:0]  rs1_tag_q  [DEPTH];
    logic [TAG_W-1:0]  rs2_tag_q  [DEPTH];
    logic [OutW-1:0]   out_q;

    logic              free_found, ready_found;
    logic [IdxW-1:0]   free_idx, sel_idx;
    logic              queue_full, dispatch_go, issue_go;
    logic              rs1_hit, rs2_hit, in_rs1_rdy, in_rs2_rdy;
    logic [31:0]       in_rs1_data, in_rs2_data;

    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        ready_found = 1'b0;
        sel_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
            if (valid_q[i] && rs1_rdy_q[i] && rs2_rdy_q[i] && !ready_found) begin
                ready_found = 1'b1;
                sel_idx     = IdxW'(i);
            end
        end
    end

    assign queue_full  = &valid_q;
    assign dispatch_go = bus.dispatch_en && !queue_full;
    assign issue_go    = (state_q == StIdle) && ready_found;

    // A pending operand can be satisfied by a broadcast in the very cycle it is dispatched.
    assign rs1_hit     = !bus.dispatch_rs1_valid && bus.cdb.cdb_valid &&
                         (bus.cdb.cdb_tag == bus.dispatch_rs1_tag);
    assign rs2_hit     = !bus.dispatch_rs2_valid && bus.cdb.cdb_valid &&
                         (bus.cdb.cdb_tag == bus.dispatch_rs2_tag);
    assign in_rs1_rdy  = bus.dispatch_rs1_valid || rs1_hit;
    assign in_rs2_rdy  = bus.dispatch_rs2_valid || rs2_hit;
    assign in_rs1_data = rs1_hit ? bus.cdb.cdb_result : bus.dispatch_data.rs1_data;
    assign in_rs2_data = rs2_hit ? bus.cdb.cdb_result : bus.dispatch_data.rs2_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]       <= '0;
                rs1_data_q[i] <= '0;
                rs2_data_q[i] <= '0;
                rs1_tag_q[i]  <= '0;
                rs2_tag_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (dispatch_go && (free_idx == IdxW'(i))) begin
                    valid_q[i]    <= 1'b1;
                    op_q[i]       <= {bus.dispatch_data.opcode, bus.dispatch_data.func3,
                                      bus.dispatch_data.func7, bus.dispatch_data.rd_tag};
                    rs1_data_q[i] <= in_rs1_data;
                    rs2_data_q[i] <= in_rs2_data;
                    rs1_rdy_q[i]  <= in_rs1_rdy;
                    rs2_rdy_q[i]  <= in_rs2_rdy;
                    rs1_tag_q[i]  <= bus.dispatch_rs1_tag;
                    rs2_tag_q[i]  <= bus.dispatch_rs2_tag;
                end else if (valid_q[i]) begin
                    if (!rs1_rdy_q[i] && bus.cdb.cdb_valid &&
                        (bus.cdb.cdb_tag == rs1_tag_q[i])) begin
                        rs1_data_q[i] <= bus.cdb.cdb_result;
                        rs1_rdy_q[i]  <= 1'b1;
                    end
                    if (!rs2_rdy_q[i] && bus.cdb.cdb_valid &&
                        (bus.cdb.cdb_tag == rs2_tag_q[i])) begin
                        rs2_data_q[i] <= bus.cdb.cdb_result;
                        rs2_rdy_q[i]  <= 1'b1;
                    end
                    if (issue_go && (sel_idx == IdxW'(i))) begin
                        valid_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (issue_go) begin
            out_q <= {op_q[sel_idx], rs1_data_q[sel_idx], rs2_data_q[sel_idx]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d                = state_q;
        bus.issue_queue_rdy    = 1'b0;
        bus.int_exec_fifo_data = '0;
        unique case (state_q)
            StIdle: begin
                if (ready_found) state_d = StIssue;
            end
            StIssue: begin
                bus.issue_queue_rdy    = 1'b1;
                bus.int_exec_fifo_data = out_q;
                state_d                = StWait;
            end
            StWait: begin
                if (bus.issue_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.queue_full = queue_full;
endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: table of fully-ready ops plus hand-written sequences
// for CDB wake-up, full queue, issue ordering, delayed completion and mid-flight reset.
module tb_int_issue_queue;
    localparam logic [6:0] R_TYPE      = 7'b0110011;
    localparam logic [6:0] I_TYPE      = 7'b0010011;
    localparam logic [6:0] LUI_TYPE    = 7'b0110111;
    localparam logic [6:0] BRANCH_TYPE = 7'b1100011;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    int_issue_queue_if #(.TAG_W(6)) bus ();

    int_issue_queue #(.DEPTH(4), .TAG_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [5:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [6:0]  exp_op;
        logic [5:0]  exp_rd;
        logic [31:0] exp_d1;
        logic [31:0] exp_d2;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.dispatch_en        = 1'b0;
        bus.dispatch_data      = '0;
        bus.dispatch_rs1_tag   = '0;
        bus.dispatch_rs2_tag   = '0;
        bus.dispatch_rs1_valid = 1'b0;
        bus.dispatch_rs2_valid = 1'b0;
        bus.cdb                = '0;
        bus.issue_done         = 1'b0;
    endtask

    task automatic disp(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [5:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic v1, input logic v2, input logic [5:0] t1,
                        input logic [5:0] t2);
        bus.dispatch_en             = 1'b1;
        bus.dispatch_data.opcode    = op;
        bus.dispatch_data.func3     = f3;
        bus.dispatch_data.func7     = f7;
        bus.dispatch_data.rd_tag    = rd;
        bus.dispatch_data.rs1_data  = d1;
        bus.dispatch_data.rs2_data  = d2;
        bus.dispatch_rs1_valid      = v1;
        bus.dispatch_rs2_valid      = v2;
        bus.dispatch_rs1_tag        = t1;
        bus.dispatch_rs2_tag        = t2;
    endtask

    task automatic cdb_put(input logic [5:0] tag, input logic [31:0] res);
        bus.cdb.cdb_valid  = 1'b1;
        bus.cdb.cdb_tag    = tag;
        bus.cdb.cdb_result = res;
    endtask

    task automatic chk_issue(input string name, input logic [5:0] rd, input logic [31:0] d1,
                             input logic [31:0] d2);
        chk({name, "_rdy"}, bus.issue_queue_rdy, 1'b1);
        chk({name, "_rd"},  bus.int_exec_fifo_data.rd_tag, rd);
        chk({name, "_rs1"}, bus.int_exec_fifo_data.rs1_data, d1);
        chk({name, "_rs2"}, bus.int_exec_fifo_data.rs2_data, d2);
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_rdy"},  bus.issue_queue_rdy, 1'b0);
        chk({name, "_data"}, bus.int_exec_fifo_data, '0);
    endtask

    task automatic done_pulse();
        bus.issue_done = 1'b1;
        tick();
        bus.issue_done = 1'b0;
    endtask

    initial begin
        vecs[0] = '{R_TYPE, 3'd0, 7'h00, 6'd3, 32'd5, 32'd7, R_TYPE, 6'd3, 32'd5, 32'd7};
        vecs[1] = '{R_TYPE, 3'd0, 7'h20, 6'd4, 32'hffff_0001, 32'h1234, R_TYPE, 6'd4,
                    32'hffff_0001, 32'h1234};
        vecs[2] = '{I_TYPE, 3'd4, 7'h00, 6'd5, 32'h0f0f, 32'hffff_fff0, I_TYPE, 6'd5,
                    32'h0f0f, 32'hffff_fff0};
        vecs[3] = '{LUI_TYPE, 3'd0, 7'h00, 6'd6, 32'd0, 32'h1234_5000, LUI_TYPE, 6'd6,
                    32'd0, 32'h1234_5000};
        vecs[4] = '{BRANCH_TYPE, 3'd1, 7'h00, 6'd63, 32'd9, 32'd10, BRANCH_TYPE, 6'd63,
                    32'd9, 32'd10};

        clr();
        rst_n = 1'b0;
        tick();
        tick();
        chk_quiet("reset");
        chk("reset_full", bus.queue_full, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_quiet("post_reset");

        // Fully-ready ops: strobe exactly two cycles after dispatch, then hold until done.
        for (int v = 0; v < 5; v++) begin
            disp(vecs[v].op, vecs[v].f3, vecs[v].f7, vecs[v].rd, vecs[v].d1, vecs[v].d2,
                 1'b1, 1'b1, 6'd0, 6'd0);
            tick();
            clr();
            chk_quiet($sformatf("vec%0d_n1", v));
            tick();
            chk_issue($sformatf("vec%0d", v), vecs[v].exp_rd, vecs[v].exp_d1, vecs[v].exp_d2);
            chk($sformatf("vec%0d_op", v), bus.int_exec_fifo_data.opcode, vecs[v].exp_op);
            tick();
            chk_quiet($sformatf("vec%0d_n3", v));
            tick();
            chk_quiet($sformatf("vec%0d_hold", v));
            done_pulse();
        end

        // rs1 pending on tag 9; a tag-8 broadcast must not wake it.
        disp(R_TYPE, 3'd0, 7'h00, 6'd7, 32'hdead_beef, 32'h22, 1'b0, 1'b1, 6'd9, 6'd0);
        tick();
        clr();
        cdb_put(6'd8, 32'h55);
        tick();
        clr();
        chk_quiet("cdb_n2");
        tick();
        chk_quiet("cdb_n3");
        cdb_put(6'd9, 32'h100);
        tick();
        clr();
        chk_quiet("cdb_n4");
        tick();
        chk_issue("cdb_wake", 6'd7, 32'h100, 32'h22);
        tick();
        done_pulse();

        // Pending operand satisfied by a broadcast in the dispatch cycle itself.
        disp(R_TYPE, 3'd0, 7'h00, 6'd8, 32'h11, 32'h999, 1'b1, 1'b0, 6'd0, 6'd12);
        cdb_put(6'd12, 32'habc);
        tick();
        clr();
        chk_quiet("same_n1");
        tick();
        chk_issue("same_cycle", 6'd8, 32'h11, 32'habc);
        tick();
        done_pulse();

        // Fill all four entries with pending ops; entries 0 and 2 share tag 20.
        disp(R_TYPE, 3'd0, 7'h00, 6'd10, 32'd0, 32'd1, 1'b0, 1'b1, 6'd20, 6'd0);
        tick();
        disp(R_TYPE, 3'd0, 7'h00, 6'd11, 32'd0, 32'd2, 1'b0, 1'b1, 6'd21, 6'd0);
        tick();
        disp(R_TYPE, 3'd0, 7'h00, 6'd12, 32'd0, 32'd3, 1'b0, 1'b1, 6'd20, 6'd0);
        tick();
        chk("fill_3_full", bus.queue_full, 1'b0);
        disp(R_TYPE, 3'd0, 7'h00, 6'd13, 32'd0, 32'd4, 1'b0, 1'b1, 6'd23, 6'd0);
        tick();
        chk("fill_4_full", bus.queue_full, 1'b1);
        disp(R_TYPE, 3'd0, 7'h00, 6'd14, 32'd77, 32'd88, 1'b1, 1'b1, 6'd0, 6'd0);
        tick();
        clr();
        chk("drop_full", bus.queue_full, 1'b1);
        tick();
        tick();
        chk_quiet("drop_no_issue");
        cdb_put(6'd20, 32'h200);
        tick();
        clr();
        chk_quiet("wake_n1");
        tick();
        chk_issue("order_e0", 6'd10, 32'h200, 32'd1);
        chk("order_freed", bus.queue_full, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_quiet($sformatf("order_wait%0d", k));
        end
        done_pulse();
        chk_quiet("order_gap");
        tick();
        chk_issue("order_e2", 6'd12, 32'h200, 32'd3);
        tick();
        chk_quiet("order_after");

        // In WAIT with entries 1 and 3 pending; add two more so the queue is full, then reset.
        disp(R_TYPE, 3'd0, 7'h00, 6'd15, 32'd0, 32'd0, 1'b0, 1'b1, 6'd30, 6'd0);
        tick();
        disp(R_TYPE, 3'd0, 7'h00, 6'd16, 32'd0, 32'd0, 1'b0, 1'b1, 6'd30, 6'd0);
        tick();
        clr();
        chk("pre_reset_full", bus.queue_full, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("async_reset");
        chk("async_reset_full", bus.queue_full, 1'b0);
        tick();
        rst_n = 1'b1;
        done_pulse();
        cdb_put(6'd21, 32'h1);
        tick();
        cdb_put(6'd23, 32'h2);
        tick();
        cdb_put(6'd30, 32'h3);
        tick();
        clr();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_quiet($sformatf("post_rst_idle%0d", k));
        end
        chk("post_rst_full", bus.queue_full, 1'b0);

        // Spurious done while idle, then two ops with a 3-cycle completion latency.
        done_pulse();
        tick();
        chk_quiet("spurious_done");
        disp(R_TYPE, 3'd0, 7'h00, 6'd40, 32'd1, 32'd2, 1'b1, 1'b1, 6'd0, 6'd0);
        tick();
        disp(R_TYPE, 3'd0, 7'h00, 6'd41, 32'd3, 32'd4, 1'b1, 1'b1, 6'd0, 6'd0);
        chk_quiet("lat_n1");
        tick();
        clr();
        chk_issue("lat_a", 6'd40, 32'd1, 32'd2);
        tick();
        chk_quiet("lat_a_w1");
        tick();
        chk_quiet("lat_a_w2");
        done_pulse();
        chk_quiet("lat_gap");
        tick();
        chk_issue("lat_b", 6'd41, 32'd3, 32'd4);
        tick();
        tick();
        tick();
        done_pulse();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_quiet($sformatf("lat_drained%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/int_issue_queue.md
# int_issue_queue

Integer reservation station feeding the integer execution unit. Accepts dispatched integer ops (R/I/LUI/branch) with operand data or producer tags, snoops the common data bus (CDB) to capture pending operands, selects one ready entry, and presents it to the execution unit as an `int_fifo_data` with a one-cycle `issue_queue_rdy` strobe. It holds off further issue until the unit returns `issue_done`, so at most one op is in flight in the integer unit.

## Interface
- `DEPTH`, 4: number of entries (power of two, ≥2).
- `TAG_W`, 6: width of rd/rs tags; matches `cdb_bfm.cdb_tag`.
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `dispatch_en` in 1: dispatch an op this cycle.
- `dispatch_data` in `int_fifo_data`: opcode, func3, func7, rd_tag, rs1/rs2 data.
- `dispatch_rs1_tag` / `dispatch_rs2_tag` in TAG_W: producer tags.
- `dispatch_rs1_valid` / `dispatch_rs2_valid` in 1: operand data already valid (I/LUI immediate arrives in rs2_data with valid=1).
- `queue_full` out 1: no free entry; dispatch is ignored while high.
- `cdb` in `cdb_bfm`: broadcast result (`cdb_valid`, `cdb_tag`, `cdb_result`).
- `issue_queue_rdy` out 1: issue strobe to the execution unit.
- `int_exec_fifo_data` out `int_fifo_data`: op being issued.
- `issue_done` in 1: execution unit finished the in-flight op.

## Operation
- Entry state: valid, op fields, rd_tag, per operand {data, tag, rdy}.
- Dispatch: if `dispatch_en && !queue_full`, write to the lowest-index free entry. For each operand with valid=0 and a same-cycle CDB match (`cdb_valid`, `cdb_tag==rsX_tag`), store `cdb_result` and set rdy=1. Otherwise store the dispatched data and valid.
- Snoop: every cycle, each valid entry with a not-ready operand whose tag matches a valid CDB broadcast captures `cdb_result` and sets rdy=1.
- Ready entry: valid && rs1 rdy && rs2 rdy, evaluated on registered state. Priority is the lowest index.
- FSM:
  - IDLE → ISSUE when any entry is ready. On this edge, copy the selected entry into the output register and clear its valid bit.
  - ISSUE (exactly 1 cycle): `issue_queue_rdy`=1, output register driven. Then go to WAIT.
  - WAIT: `issue_queue_rdy`=0. Go to IDLE on the cycle `issue_done`=1.
  - `issue_done` in IDLE or ISSUE is ignored.
- `int_exec_fifo_data` is driven to all zeros whenever `issue_queue_rdy`=0.
- `queue_full` = all entries valid, taken from registered state. An entry freed on the same edge becomes available to dispatch on the following cycle.
- Branch ops (opcode BRANCH_TYPE) issue like any other op; rd_tag is passed unchanged.

## Timing
- Reset (async, immediate): all entries invalid, FSM=IDLE, `issue_queue_rdy`=0, `int_exec_fifo_data`=0, `queue_full`=0.
- Reset mid-operation: the in-flight op and all entries are discarded. Any `issue_done` arriving after reset release while in IDLE is ignored.
- Dispatch-to-issue latency with both operands valid: dispatch at cycle N, ready at N+1 (IDLE → ISSUE edge at end of N+1), `issue_queue_rdy` high in N+2.
- An operand captured from the CDB in cycle N makes its entry eligible in cycle N+1.
- Back-to-back throughput: next `issue_queue_rdy` occurs no earlier than 2 cycles after the `issue_done` cycle (WAIT→IDLE, then IDLE→ISSUE).
- Dispatch and CDB capture proceed in every FSM state.

## Test plan
- Reset, then dispatch ADD (opcode R_TYPE, func3=0, func7=0), rs1=5, rs2=7, both valid, rd_tag=3 → `issue_queue_rdy` pulses 1 cycle, 2 cycles after dispatch, with rs1_data=5, rs2_data=7, rd_tag=3. No second strobe until `issue_done`.
- Dispatch with rs1 pending on tag 9; 3 cycles later CDB {valid=1, tag=9, result=0x100} → entry issues with rs1_data=0x100. A CDB broadcast of tag 8 has no effect.
- Dispatch with a pending operand in the same cycle as a matching CDB broadcast → value captured at dispatch, op issues without waiting for another broadcast.
- Fill DEPTH=4 entries with pending ops → `queue_full`=1, 5th dispatch dropped. Wake entries 2 and 0 together → entry 0 issues first, entry 2 issues only after `issue_done` returns.
- With `issue_done` delayed 3 cycles (LATENCY=3) → exactly one `issue_queue_rdy` per `issue_done`. A spurious `issue_done` while IDLE changes nothing.
- Assert `rst_n`=0 in WAIT with 2 entries valid → all outputs 0 immediately. After release, no issue occurs without a new dispatch.
